sm83_bus_seq: RTL and testbench
===============================

// Module: sm83_bus_seq
// PURPOSE
//   M-cycle bus sequencer between the SM83 core's memory request port and the
//   ROM/RAM memory models. Accepts one read or write per handshake and steps it
//   through T1..T4 (plus optional wait states). Decodes ROM vs RAM by address,
//   drives the combinational-read / posedge-write memory ports and returns read
//   data on a one-cycle response pulse. Writes into the ROM region are blocked.
// PARAMETERS
//   ROM_TOP      16'h7FFF  last address of ROM region; addr <= ROM_TOP -> ROM, else RAM
//   WAIT_STATES  0         extra T2 cycles per access (0..15)
// PORTS
//   clk          in   1   system clock
//   rst_n        in   1   reset, asynchronous, active-low
//   req_valid    in   1   core presents a request
//   req_ready    out  1   sequencer can accept; transfer on req_valid && req_ready
//   req_we       in   1   1 = write, 0 = read
//   req_addr     in   16  addr_t request address
//   req_wdata    in   8   data_t write data
//   rsp_valid    out  1   one-cycle completion pulse (reads and writes)
//   rsp_rdata    out  8   read data, valid with rsp_valid; holds last read value
//   rsp_err      out  1   with rsp_valid: write targeted ROM region, dropped
//   rom_addr     out  16  ROM read address
//   rom_r_data   in   8   ROM combinational read data
//   ram_r_addr   out  16  RAM read address
//   ram_w_addr   out  16  RAM write address
//   ram_w_data   out  8   RAM write data
//   ram_wen      out  1   RAM write enable, sampled by RAM at posedge
//   ram_r_data   in   8   RAM combinational read data
//   acc_count    out  16  completed-access counter, wraps FFFF->0000
// BEHAVIOUR
//   - One clock domain; rst_n async assert, sync deassert by upstream. Reset:
//     state IDLE, req_ready 1, rsp_valid/rsp_err/ram_wen 0, rsp_rdata 8'h00,
//     all addresses/ram_w_data 0, acc_count 0, wait counter 0.
//   - States: IDLE, T1, T2, T3, T4. Request latched (we, addr, wdata, is_rom =
//     addr <= ROM_TOP) on the accepting edge; state -> T1.
//   - req_ready = 1 in IDLE and T4 only (back-to-back: accept in T4 -> T1).
//   - T1: rom_addr/ram_r_addr/ram_w_addr/ram_w_data driven from latch (held
//     stable until next accept). -> T2, wait counter loaded with WAIT_STATES.
//   - T2: if counter != 0 decrement, stay; else -> T3.
//   - T3: read: capture (is_rom ? rom_r_data : ram_r_data) into rsp_rdata at
//     end of T3. Write to RAM: ram_wen = 1 for exactly the T3 cycle (RAM
//     updates on T3->T4 edge). Write to ROM: ram_wen stays 0. -> T4.
//   - T4: rsp_valid = 1; rsp_err = we && is_rom; acc_count increments at end of
//     T4. If req_valid -> T1 (new latch) else -> IDLE.
//   - Latency: accept edge to rsp_valid cycle = 4 + WAIT_STATES cycles; peak
//     throughput one access per 4 + WAIT_STATES cycles.
//   - rsp_rdata is unchanged by writes; rsp_err is 0 outside rsp_valid.
//   - Boundaries: ROM_TOP itself is ROM, ROM_TOP+1 is RAM; 16'hFFFF is RAM.
//     req inputs ignored when req_ready = 0 (no buffering; core must hold).
//   - Reset mid-access: immediate return to reset values; in-flight write not
//     performed unless its posedge already occurred; no rsp_valid issued.
// TESTING
//   1. Read 16'h0100, ROM[0100]=8'h3E, WAIT_STATES=0 -> rsp_valid 4 cycles after
//      accept, rsp_rdata=8'h3E, rsp_err=0, ram_wen never high.
//   2. Write 8'hA5 to 16'hC000 then read 16'hC000 -> ram_wen high one cycle
//      (T3) with w_addr C000; read returns 8'hA5; acc_count = 2.
//   3. Write 8'h55 to 16'h7FFF -> rsp_err=1, ram_wen=0, ROM unchanged; write to
//      16'h8000 -> rsp_err=0, RAM[8000]=8'h55.
//   4. req_valid held high for 3 reads, WAIT_STATES=2 -> req_ready high only in
//      T4, rsp_valid every 6 cycles, data in request order.
//   5. rst_n low during T3 of a RAM write -> ram_wen drops asynchronously, no
//      rsp_valid, RAM location unchanged, acc_count = 0 after release.
//   6. acc_count preset via 65535 accesses (or force) -> next completion wraps
//      to 16'h0000.

Source files
------------

// File: rtl/sm83_bus_seq.sv
// ---------------------------------------------------------------------------
// sm83_bus_seq
//
// M-cycle bus sequencer between the SM83 core's memory request port and the
// ROM/RAM memory models. One read or write is accepted per valid/ready
// handshake and stepped through T1..T4, with WAIT_STATES extra T2 cycles.
// The address decodes to ROM (addr <= ROM_TOP) or RAM. Read data is returned
// on a one-cycle response pulse in T4. Writes aimed at ROM are dropped and
// flagged with rsp_err.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (transfer when both high)
//   req_we/addr/wdata        request attributes, latched on the accepting edge
//   rsp_valid/rdata/err      completion pulse, read data (held), ROM-write flag
//   rom_addr, rom_r_data     ROM port (combinational read)
//   ram_r_addr, ram_r_data   RAM read port (combinational read)
//   ram_w_addr/w_data/wen    RAM write port (written at posedge when wen)
//   acc_count                completed-access counter, wraps
// ---------------------------------------------------------------------------
module sm83_bus_seq #(
  parameter logic [15:0] ROM_TOP     = 16'h7FFF,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_r_data,
  output logic [15:0] ram_r_addr,
  output logic [15:0] ram_w_addr,
  output logic [7:0]  ram_w_data,
  output logic        ram_wen,
  input  logic [7:0]  ram_r_data,
  output logic [15:0] acc_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t      state_q,  state_d;
  logic        we_q,     we_d;
  logic        is_rom_q, is_rom_d;
  logic [15:0] addr_q,   addr_d;
  logic [7:0]  wdata_q,  wdata_d;
  logic [3:0]  wait_q,   wait_d;
  logic [7:0]  rdata_q,  rdata_d;
  logic [15:0] acc_q,    acc_d;
  logic        accept;

  // State register and request latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      is_rom_q <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      wait_q   <= 4'd0;
      rdata_q  <= 8'h00;
      acc_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      is_rom_q <= is_rom_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      acc_q    <= acc_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    is_rom_d  = is_rom_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    acc_d     = acc_q;
    accept    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    ram_wen   = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = S_T1;
        end
      end
      S_T1: begin
        wait_d  = WAIT_INIT;
        state_d = S_T2;
      end
      S_T2: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          state_d = S_T3;
        end
      end
      S_T3: begin
        // Write enable is decoded from state so an async reset drops it at once.
        if (we_q) begin
          ram_wen = !is_rom_q;
        end else begin
          rdata_d = is_rom_q ? rom_r_data : ram_r_data;
        end
        state_d = S_T4;
      end
      S_T4: begin
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_err   = we_q && is_rom_q;
        acc_d     = acc_q + 16'd1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = S_T1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      we_d     = req_we;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
      is_rom_d = (req_addr <= ROM_TOP);
    end
  end

  // Memory ports follow the latch, so they stay stable until the next accept.
  assign rom_addr   = addr_q;
  assign ram_r_addr = addr_q;
  assign ram_w_addr = addr_q;
  assign ram_w_data = wdata_q;
  assign rsp_rdata  = rdata_q;
  assign acc_count  = acc_q;

endmodule

// File: tb/tb_sm83_bus_seq.sv
module tb_sm83_bus_seq;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err, ram_wen;
  logic [7:0]  rsp_rdata, ram_w_data, ram_r_data, rom_r_data;
  logic [15:0] rom_addr, ram_r_addr, ram_w_addr, acc_count;

  logic        req_valid2, req_ready2, req_we2;
  logic [15:0] req_addr2;
  logic [7:0]  req_wdata2;
  logic        rsp_valid2, rsp_err2, ram_wen2;
  logic [7:0]  rsp_rdata2, ram_w_data2, rom_r_data2;
  logic [15:0] rom_addr2, ram_r_addr2, ram_w_addr2, acc_count2;

  logic [7:0]  ram [0:65535];
  int          wen_cycles;
  int          rsp_count;
  logic [15:0] last_w_addr;
  logic [7:0]  last_w_data;

  int passed;
  int failed;
  int total;

  function automatic logic [7:0] rom_val(input logic [15:0] a);
    if (a == 16'h0100) return 8'h3E;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  sm83_bus_seq #(.ROM_TOP(16'h7FFF), .WAIT_STATES(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rom_addr(rom_addr), .rom_r_data(rom_r_data),
    .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_wen(ram_wen), .ram_r_data(ram_r_data), .acc_count(acc_count)
  );

  sm83_bus_seq #(.ROM_TOP(16'h7FFF), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
    .rom_addr(rom_addr2), .rom_r_data(rom_r_data2),
    .ram_r_addr(ram_r_addr2), .ram_w_addr(ram_w_addr2), .ram_w_data(ram_w_data2),
    .ram_wen(ram_wen2), .ram_r_data(8'h00), .acc_count(acc_count2)
  );

  assign rom_r_data  = rom_val(rom_addr);
  assign rom_r_data2 = rom_val(rom_addr2);
  assign ram_r_data  = ram[ram_r_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wen) begin
      ram[ram_w_addr] <= ram_w_data;
      wen_cycles      <= wen_cycles + 1;
      last_w_addr     <= ram_w_addr;
      last_w_data     <= ram_w_data;
    end
    if (rsp_valid) rsp_count <= rsp_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One handshake on dut; returns cycles from accept edge to rsp_valid.
  task automatic access(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                        output int lat, output logic [7:0] rd, output logic err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    rd  = rsp_rdata;
    err = rsp_err;
    @(negedge clk);
  endtask

  int          lat;
  logic [7:0]  rd;
  logic        err;
  int          wen_base;
  int          rsp_base;
  logic [15:0] addrs [0:2];
  int          k_acc;
  int          k_rsp;

  initial begin
    passed = 0; failed = 0; total = 0;
    wen_cycles = 0; rsp_count = 0;
    last_w_addr = 16'h0; last_w_data = 8'h0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 16'h0; req_wdata = 8'h0;
    req_valid2 = 0; req_we2 = 0; req_addr2 = 16'h0; req_wdata2 = 8'h0;
    addrs[0] = 16'h0010; addrs[1] = 16'h0020; addrs[2] = 16'h7FFF;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst_rspv",   {31'd0, rsp_valid}, 32'd0);
    chk("rst_err",    {31'd0, rsp_err}, 32'd0);
    chk("rst_wen",    {31'd0, ram_wen}, 32'd0);
    chk("rst_rdata",  {24'd0, rsp_rdata}, 32'h00);
    chk("rst_romadr", {16'd0, rom_addr}, 32'h0);
    chk("rst_wadr",   {16'd0, ram_w_addr}, 32'h0);
    chk("rst_wdata",  {24'd0, ram_w_data}, 32'h0);
    chk("rst_acc",    {16'd0, acc_count}, 32'h0);
    rst_n = 1'b1;

    // 1: ROM read
    wen_base = wen_cycles;
    access(1'b0, 16'h0100, 8'h00, lat, rd, err);
    chk("t1_lat",   lat, 32'd4);
    chk("t1_rdata", {24'd0, rd}, 32'h3E);
    chk("t1_err",   {31'd0, err}, 32'd0);
    chk("t1_wen",   wen_cycles - wen_base, 32'd0);
    chk("t1_acc",   {16'd0, acc_count}, 32'd1);

    // Clean counter for the write/read pair
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_acc", {16'd0, acc_count}, 32'd0);
    rst_n = 1'b1;

    // 2: RAM write then read
    wen_base = wen_cycles;
    access(1'b1, 16'hC000, 8'hA5, lat, rd, err);
    chk("t2_wlat",  lat, 32'd4);
    chk("t2_werr",  {31'd0, err}, 32'd0);
    chk("t2_wen",   wen_cycles - wen_base, 32'd1);
    chk("t2_wadr",  {16'd0, last_w_addr}, 32'hC000);
    chk("t2_wdat",  {24'd0, last_w_data}, 32'hA5);
    chk("t2_rdhold", {24'd0, rsp_rdata}, 32'h00);
    access(1'b0, 16'hC000, 8'h00, lat, rd, err);
    chk("t2_rdata", {24'd0, rd}, 32'hA5);
    chk("t2_acc",   {16'd0, acc_count}, 32'd2);

    // 3: ROM-region write dropped, RAM boundary writes land
    wen_base = wen_cycles;
    access(1'b1, 16'h7FFF, 8'h55, lat, rd, err);
    chk("t3_romerr", {31'd0, err}, 32'd1);
    chk("t3_romwen", wen_cycles - wen_base, 32'd0);
    chk("t3_erridle", {31'd0, rsp_err}, 32'd0);
    access(1'b0, 16'h7FFF, 8'h00, lat, rd, err);
    chk("t3_romrd", {24'd0, rd}, 32'hDA);
    access(1'b1, 16'h8000, 8'h55, lat, rd, err);
    chk("t3_ramerr", {31'd0, err}, 32'd0);
    chk("t3_ram8000", {24'd0, ram[16'h8000]}, 32'h55);
    access(1'b0, 16'h8000, 8'h00, lat, rd, err);
    chk("t3_rd8000", {24'd0, rd}, 32'h55);
    access(1'b1, 16'hFFFF, 8'h12, lat, rd, err);
    chk("t3_ffferr", {31'd0, err}, 32'd0);
    access(1'b0, 16'hFFFF, 8'h00, lat, rd, err);
    chk("t3_rdffff", {24'd0, rd}, 32'h12);

    // 4: back-to-back reads with two wait states
    k_acc = 0; k_rsp = 0;
    @(negedge clk);
    req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = addrs[0];
    for (int cyc = 0; cyc <= 18; cyc++) begin
      if (cyc != 0) @(negedge clk);
      chk("t4_ready", {31'd0, req_ready2}, {31'd0, (cyc % 6 == 0)});
      chk("t4_rspv",  {31'd0, rsp_valid2}, {31'd0, (cyc != 0 && cyc % 6 == 0)});
      if (rsp_valid2 && k_rsp < 3) begin
        chk("t4_rdata", {24'd0, rsp_rdata2}, {24'd0, rom_val(addrs[k_rsp])});
        k_rsp++;
      end
      if (req_ready2 && req_valid2) begin
        @(posedge clk);
        #1;
        k_acc++;
        if (k_acc < 3) req_addr2 = addrs[k_acc];
        else req_valid2 = 1'b0;
      end
    end
    chk("t4_nrsp", k_rsp, 32'd3);

    // 5: reset during T3 of a RAM write
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'hC100; req_wdata = 8'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_wenT3", {31'd0, ram_wen}, 32'd1);
    rsp_base = rsp_count;
    rst_n = 1'b0;
    #1;
    chk("t5_wenrst", {31'd0, ram_wen}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_norsp", rsp_count - rsp_base, 32'd0);
    chk("t5_ram",   {24'd0, ram[16'hC100]}, 32'h00);
    chk("t5_acc",   {16'd0, acc_count}, 32'd0);

    // 6: counter wrap
    force dut.acc_q = 16'hFFFF;
    @(negedge clk);
    release dut.acc_q;
    @(negedge clk);
    chk("t6_pre", {16'd0, acc_count}, 32'hFFFF);
    access(1'b0, 16'h0100, 8'h00, lat, rd, err);
    chk("t6_wrap", {16'd0, acc_count}, 32'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
